// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter slice: datapath width,
// shift op encoding, FSM state encoding and a small one-hot grant helper.
package shift_pkg;

  localparam int N       = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  // Turn a requester index into its one-hot ready vector.
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational shift unit: log-stage SLL, SRL and SRA barrel shifters
// followed by an op-select mux. The reserved op passes data through.
module shift_unit
  import shift_pkg::*;
(
  input  logic [1:0]         op,
  input  logic [N-1:0]       data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [N-1:0]       result
);

  // Stage gi shifts by 2**gi when shamt[gi] is set; stage 0 is the operand.
  logic [N-1:0] sll_stage [0:SHAMT_W];
  logic [N-1:0] srl_stage [0:SHAMT_W];
  logic [N-1:0] sra_stage [0:SHAMT_W];

  assign sll_stage[0] = data;
  assign srl_stage[0] = data;
  assign sra_stage[0] = data;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int SH = 1 << gi;

      // Left shift fills the vacated LSBs with zeros.
      assign sll_stage[gi+1] = shamt[gi]
                             ? {sll_stage[gi][N-1-SH:0], {SH{1'b0}}}
                             : sll_stage[gi];

      // Logical right shift fills the vacated MSBs with zeros.
      assign srl_stage[gi+1] = shamt[gi]
                             ? {{SH{1'b0}}, srl_stage[gi][N-1:SH]}
                             : srl_stage[gi];

      // Arithmetic right shift replicates the sign bit; every stage keeps
      // bit N-1 equal to the original data[N-1], so it is safe to reuse.
      assign sra_stage[gi+1] = shamt[gi]
                             ? {{SH{sra_stage[gi][N-1]}}, sra_stage[gi][N-1:SH]}
                             : sra_stage[gi];
    end
  endgenerate

  // Select the shifter matching the op; reserved op returns data unchanged.
  always_comb begin
    result = data;
    case (shift_op_t'(op))
      SHIFT_SLL:  result = sll_stage[SHAMT_W];
      SHIFT_SRL:  result = srl_stage[SHAMT_W];
      SHIFT_SRA:  result = sra_stage[SHAMT_W];
      SHIFT_RSVD: result = data;
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester shift arbiter. One request is accepted in IDLE, its shift
// result is registered and presented in RESP until the consumer takes it.
// Build option: define SHIFT_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise requester 0 wins ties (fixed priority).
module shift_arbiter
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_op0,
  input  logic [1:0]         req_op1,
  input  logic [N-1:0]       req_data0,
  input  logic [N-1:0]       req_data1,
  input  logic [SHAMT_W-1:0] req_shamt0,
  input  logic [SHAMT_W-1:0] req_shamt1,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [N-1:0]       resp_data
);

  state_t       state_reg, state_next;
  logic         grant_id;
  logic         accept;
  logic [1:0]   sel_op;
  logic [N-1:0] sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [N-1:0] shift_result;
  logic [N-1:0] resp_data_reg;
  logic         resp_id_reg;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  // Index of the most recently accepted requester; reset to 1 so that
  // requester 0 wins the first tie after reset.
  logic         last_grant_reg;

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant_id = ~last_grant_reg;
    end
  end

  // Remember the winner, only when a transfer actually happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant_id;
    end
  end
`else
  // Grant: a lone requester wins; on a tie requester 0 always wins.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end
  end
`endif

  // Route the granted requester's operands into the shift unit.
  always_comb begin
    sel_op    = grant_id ? req_op1    : req_op0;
    sel_data  = grant_id ? req_data1  : req_data0;
    sel_shamt = grant_id ? req_shamt1 : req_shamt0;
  end

  shift_unit u_shift_unit (
    .op     (sel_op),
    .data   (sel_data),
    .shamt  (sel_shamt),
    .result (shift_result)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake: ready only in IDLE, never during reset, and
  // the response hand-off never overlaps a new accept.
  always_comb begin
    state_next = state_reg;
    req_ready  = 2'b00;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready  = onehot2(grant_id);
          accept     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the result and owner on accept; hold them through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_reg <= '0;
      resp_id_reg   <= 1'b0;
    end else if (accept) begin
      resp_data_reg <= shift_result;
      resp_id_reg   <= grant_id;
    end
  end

  assign resp_valid = (state_reg == S_RESP);
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed corner cases followed by
// randomized traffic compared against a transaction-level reference model.
module tb_shift_arbiter;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [31:0] req_data0, req_data1;
  logic [4:0]  req_shamt0, req_shamt1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_shamt0 (req_shamt0),
    .req_shamt1 (req_shamt1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: is a result outstanding, whose is it, what is it.
  bit          m_busy;
  int          m_id;
  logic [31:0] m_data;
  int          m_last;
  bit          acc_happened;
  int          acc_who;
  int          n_txn = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  function automatic int ref_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (RR) return (m_last == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_data = 32'h0;
    m_last = 1;
  endtask

  // One clock cycle. Inputs are already driven at the falling edge; check
  // outputs, let the rising edge happen, advance the model, return at the
  // next falling edge.
  task automatic step();
    logic [1:0] er;
    int g;
    #1;
    er = 2'b00;
    if (!m_busy && req_valid != 2'b00) er = (ref_grant(req_valid) == 1) ? 2'b10 : 2'b01;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), 32'(m_busy));
    if (m_busy) begin
      chk("resp_id", 32'(resp_id), 32'(m_id));
      chk("resp_data", resp_data, m_data);
    end
    acc_happened = 1'b0;
    @(posedge clk);
    if (!m_busy && req_valid != 2'b00) begin
      g      = ref_grant(req_valid);
      m_id   = g;
      m_data = (g == 1) ? ref_shift(req_op1, req_data1, req_shamt1)
                        : ref_shift(req_op0, req_data0, req_shamt0);
      m_busy = 1'b1;
      m_last = g;
      acc_happened = 1'b1;
      acc_who = g;
      n_txn++;
      $display("txn %0d: accept req%0d op=%0d data=%h shamt=%0d -> expect %h", n_txn, g,
               (g == 1) ? req_op1 : req_op0, (g == 1) ? req_data1 : req_data0,
               (g == 1) ? req_shamt1 : req_shamt0, m_data);
    end else if (m_busy && resp_ready) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  // Single-requester directed transfer; leaves the bench in RESP.
  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] s);
    resp_ready = 1'b0;
    req_valid  = (r == 1) ? 2'b10 : 2'b01;
    if (r == 1) begin
      req_op1 = op; req_data1 = d; req_shamt1 = s;
    end else begin
      req_op0 = op; req_data0 = d; req_shamt0 = s;
    end
    step();
    req_valid = 2'b00;
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  logic [1:0]  r_op   [2];
  logic [31:0] r_data [2];
  logic [4:0]  r_sh   [2];
  bit          pend   [2];
  int          ids    [$];
  int          exp_seq[3];

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; resp_ready = 1'b0;
    req_op0 = 2'b00; req_op1 = 2'b00;
    req_data0 = 32'h0; req_data1 = 32'h0;
    req_shamt0 = 5'd0; req_shamt1 = 5'd0;
    model_reset();

    // Reset state, with a request pending to prove ready stays low.
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;

    // Both requesters held for 3 transactions.
    req_valid = 2'b11; resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_op0 = 2'($urandom_range(0, 3)); req_data0 = $urandom; req_shamt0 = 5'($urandom);
      req_op1 = 2'($urandom_range(0, 3)); req_data1 = $urandom; req_shamt1 = 5'($urandom);
      step();
      if (acc_happened) ids.push_back(acc_who);
    end
    req_valid = 2'b00;
    step();
    exp_seq = RR ? '{0, 1, 0} : '{0, 0, 0};
    chk("tie_count", 32'(ids.size()), 32'd3);
    for (int i = 0; i < 3 && i < ids.size(); i++) chk("tie_seq", 32'(ids[i]), 32'(exp_seq[i]));

    // Shift corner cases.
    issue(0, 2'b10, 32'h80000000, 5'd4);
    chk("sra4", resp_data, 32'hF8000000);
    chk("sra4_id", 32'(resp_id), 32'h0);
    drain();
    issue(1, 2'b01, 32'h80000000, 5'd31);
    chk("srl31", resp_data, 32'h00000001);
    chk("srl31_id", 32'(resp_id), 32'h1);
    drain();
    issue(1, 2'b00, 32'h00000001, 5'd31);
    chk("sll31", resp_data, 32'h80000000);
    drain();
    issue(0, 2'b11, 32'h1234ABCD, 5'd7);
    chk("rsvd", resp_data, 32'h1234ABCD);
    drain();
    issue(1, 2'b10, 32'h7FFF0000, 5'd0);
    chk("sra0", resp_data, 32'h7FFF0000);
    drain();

    // Back-pressure: result held 3 cycles with requests waiting.
    issue(1, 2'b00, 32'h0000F00F, 5'd8);
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", resp_data, 32'h00F00F00);
    end
    resp_ready = 1'b1;
    step();
    chk("bp_back_idle_ready", 32'(req_ready != 2'b00), 32'h1);
    step();
    req_valid = 2'b00;
    step();

    // Asynchronous reset in the middle of RESP.
    issue(0, 2'b10, 32'h80000000, 5'd4);
    chk("pre_rst_data", resp_data, 32'hF8000000);
    req_valid = 2'b11;
    #2 rst = 1'b1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 32'h0);
    chk("arst_resp_data", resp_data, 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("post_rst_grant", 32'(acc_who), 32'h0);
    req_valid = 2'b00;
    step();

    // Randomized traffic; each requester holds its request until accepted.
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r]   = 1'b1;
          r_op[r]   = 2'($urandom_range(0, 3));
          r_data[r] = $urandom;
          case ($urandom_range(0, 3))
            0:       r_sh[r] = 5'd0;
            1:       r_sh[r] = 5'd31;
            default: r_sh[r] = 5'($urandom);
          endcase
        end
      end
      req_valid  = {pend[1], pend[0]};
      req_op0 = r_op[0]; req_data0 = r_data[0]; req_shamt0 = r_sh[0];
      req_op1 = r_op[1]; req_data1 = r_data[1]; req_shamt1 = r_sh[1];
      resp_ready = 1'($urandom_range(0, 1));
      step();
      if (acc_happened) pend[acc_who] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 N, 32, datapath width; fixed constant, only 32 supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept, bit i = requester i.
REQ-006 req_op0, req_op1  input  2 each  shift op: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-007 req_data0, req_data1  input  N each  operand to shift.
REQ-008 req_shamt0, req_shamt1  input  5 each  shift amount, 0..31.
REQ-009 resp_valid  output  1  result valid.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_id  output  1  index of the requester that owns resp_data.
REQ-012 resp_data  output  N  shift result.

Function
REQ-013 Two-state FSM, IDLE and RESP; a transfer occurs when req_valid[i] and req_ready[i] are both high on a rising edge.
REQ-014 req_ready SHALL be nonzero only in IDLE, one-hot, set for the granted requester only, and zero in RESP.
REQ-015 Grant is combinational from req_valid and last_grant; only one valid requester -> that requester is granted.
REQ-016 Accept in IDLE -> next cycle RESP, resp_valid=1, resp_id=granted index, resp_data=shift of accepted operands (latency 1 cycle).
REQ-017 SLL zero-fills LSBs; SRL zero-fills MSBs; SRA fills MSBs with data[31]; shamt=0 returns data unchanged.
REQ-018 Reserved op 11 SHALL return data unchanged, regardless of shamt.
REQ-019 In RESP, resp_valid, resp_id and resp_data SHALL hold stable until resp_ready=1.
REQ-020 In RESP with resp_ready=1 -> IDLE next cycle; no new accept in that same cycle (max throughput 1 per 2 cycles).
REQ-021 last_grant updates only on an accept; req_valid changes while not accepted SHALL not alter state.
REQ-022 Requesters hold req_valid and operands until accepted; the block does not latch unaccepted requests.

Reset
REQ-023 rst asserted, including mid-RESP -> state IDLE, resp_valid=0, resp_id=0, resp_data=0, last_grant=1; any pending result is dropped.
REQ-024 req_ready SHALL be 0 while rst is high.

Configuration
REQ-025 SHIFT_ARB_ROUND_ROBIN_EN defined: both valid in IDLE -> grant requester != last_grant (requester 0 first after reset).
REQ-026 SHIFT_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties; last_grant unused.

Structure
REQ-027 Package shift_pkg: N=32, shift_op_t enum (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_RSVD=2'b11), fsm state enum (S_IDLE, S_RESP).
REQ-028 One sub-module, shift_unit: combinational op/data/shamt -> result, built from the team's existing SLL/SRL/SRA shifters plus an op-select mux.
REQ-029 The arbiter muxes the granted requester's operands into shift_unit and registers its output into resp_data on accept.

Verification
REQ-030 Req0 SRA data=0x80000000 shamt=4 -> one cycle later resp_valid=1, resp_id=0, resp_data=0xF8000000.
REQ-031 Req1 SRL 0x80000000 shamt=31 -> resp_data=0x00000001; req1 SLL 0x00000001 shamt=31 -> 0x80000000; op 11 data=0x1234ABCD shamt=7 -> 0x1234ABCD.
REQ-032 Both requesters held valid for 3 transactions, round-robin build -> resp_id sequence 0,1,0; fixed-priority build -> 0,0,0.
REQ-033 resp_ready held low 3 cycles after result -> resp_valid/resp_id/resp_data stable, req_ready=2'b00 throughout; IDLE one cycle after resp_ready=1.
REQ-034 rst pulsed while in RESP with resp_data=0xF8000000 -> resp_valid=0 and resp_data=0 immediately (asynchronous); next accept with both valid grants requester 0.
